wb_arbiter_2m: RTL and testbench

- Two-master, one-slave Wishbone classic arbiter with round-robin priority.
- Sits between the picorv32_wb core (master 0) and a second master (DMA / program loader, master 1), in front of the shared word-addressed memory slave.
- Grant is held for the whole bus cycle (cyc-locked), so read-modify-write sequences from one master are never interleaved.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_arb_rr_pick.sv | 13 +
 rtl/wb_arbiter_2m.sv | 170 +++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, grant encodings, default stall limit.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam int DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the master that did not win last time is chosen.
// Zero latency; no backpressure, purely a function of req and last.
module wb_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick,
  output logic       valid
);

  assign valid = |req;
  assign pick  = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter, round-robin, grant locked for the whole cyc; s_cyc_o follows one clock after request.
// Optional WB_ARB_TIMEOUT_EN: stalled strobes are terminated with a one-cycle err to the granted master.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int SW             = DW / 8,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  input  logic          m0_we_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic          m0_stb_i,
  input  logic          m0_cyc_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  input  logic          m1_we_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic          m1_stb_i,
  input  logic          m1_cyc_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic          s_we_o,
  output logic [SW-1:0] s_sel_o,
  output logic          s_stb_o,
  output logic          s_cyc_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  output logic [1:0]    grant_o
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       pick, pick_vld;
  logic       stb_raw;
  logic       tmo;

  wb_arb_rr_pick u_pick (
    .req   ({m1_cyc_i, m0_cyc_i}),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Release hands straight to the other master if it is waiting; s_cyc_o is already low that cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = pick ? GNT1 : GNT0;
          last_d  = pick;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          if (m1_cyc_i) begin
            state_d = GNT1;
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          if (m0_cyc_i) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_cyc_o  = 1'b0;
    stb_raw  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = GRANT_NONE;
    case (state_q)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_cyc_o  = m0_cyc_i;
        stb_raw  = m0_stb_i & m0_cyc_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | tmo;
        grant_o  = GRANT_M0;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_cyc_o  = m1_cyc_i;
        stb_raw  = m1_stb_i & m1_cyc_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | tmo;
        grant_o  = GRANT_M1;
      end
      default: ;
    endcase
  end

  // The timeout cycle withdraws the strobe so the slave never sees the aborted access complete.
  assign s_stb_o = stb_raw & ~tmo;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 32) ? 32 : TW_RAW);

  logic [TW-1:0] cnt_q;

  assign tmo = (cnt_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else if (s_ack_i || s_err_i || tmo || (state_d != state_q)) begin
      cnt_q <= '0;
    end else if (s_cyc_o && stb_raw) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign tmo        = 1'b0;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m with a one-cycle-ack word memory slave.
module tb_wb_arbiter_2m;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m1_adr_i = '0, m1_dat_i = '0;
  logic        m0_we_i = 1'b0, m0_stb_i = 1'b0, m0_cyc_i = 1'b0;
  logic        m1_we_i = 1'b0, m1_stb_i = 1'b0, m1_cyc_i = 1'b0;
  logic [3:0]  m0_sel_i = 4'hf, m1_sel_i = 4'hf;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  logic        ack_q, ack_force = 1'b0, err_force = 1'b0, slave_mute = 1'b0;
  logic [31:0] mem [0:255];
  int          tests = 0;
  int          fails = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_arbiter_2m #(.AW(32), .DW(32), .SW(4), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_stb_o(s_stb_o),
    .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
  );

  assign s_dat_i = mem[s_adr_o[9:2]];
  assign s_ack_i = ack_q | ack_force;
  assign s_err_i = err_force;

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      mem[0]   <= 32'h3fc00093;
      mem[255] <= 32'h00000011;
    end else begin
      ack_q <= s_cyc_o & s_stb_o & ~ack_q & ~slave_mute;
      if (s_cyc_o && s_stb_o && !ack_q && !slave_mute && s_we_o)
        mem[s_adr_o[9:2]] <= s_dat_o;
    end
  end

  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  task automatic wait_ack(input int m, output logic got, output logic [31:0] rd);
    got = 1'b0;
    rd  = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge wb_clk_i);
      if ((m == 0) ? m0_ack_o : m1_ack_o) begin
        got = 1'b1;
        rd  = (m == 0) ? m0_dat_o : m1_dat_o;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    #1;
    tests++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_we_o !== 1'b0) begin
      fails++; $display("FAIL reset_bus cyc/stb/we=%b%b%b want 000", s_cyc_o, s_stb_o, s_we_o); end
    tests++; if (grant_o !== 2'b00) begin fails++; $display("FAIL reset_grant got %b want 00", grant_o); end
    tests++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_ackerr got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
    tests++; if (s_adr_o !== 32'h0 || s_dat_o !== 32'h0 || s_sel_o !== 4'h0) begin
      fails++; $display("FAIL reset_adr_dat adr=%h dat=%h sel=%h want 0", s_adr_o, s_dat_o, s_sel_o); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;
  endtask

  task automatic test_single_read();
    logic got; logic [31:0] rd;
    @(posedge wb_clk_i); #1 drive(0, 1, 1, 0, 32'h0, 32'h0);
    @(negedge wb_clk_i);
    tests++; if (s_cyc_o !== 1'b0) begin fails++; $display("FAIL rd_latency0 s_cyc_o got %b want 0", s_cyc_o); end
    @(negedge wb_clk_i);
    tests++; if (s_cyc_o !== 1'b1 || grant_o !== 2'b01) begin
      fails++; $display("FAIL rd_grant cyc=%b grant=%b want 1/01", s_cyc_o, grant_o); end
    wait_ack(0, got, rd);
    tests++; if (got !== 1'b1 || rd !== 32'h3fc00093) begin
      fails++; $display("FAIL rd_data got ack=%b dat=%h want 1/3fc00093", got, rd); end
    tests++; if (m1_ack_o !== 1'b0) begin fails++; $display("FAIL rd_m1_ack got %b want 0", m1_ack_o); end
    @(posedge wb_clk_i); #1 drive(0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge wb_clk_i); @(negedge wb_clk_i);
    tests++; if (grant_o !== 2'b00) begin fails++; $display("FAIL rd_release grant got %b want 00", grant_o); end
  endtask

  task automatic test_tie_alternate();
    logic got; logic [31:0] rd;
    pulse_reset();
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge wb_clk_i); #1 drive(0, 1, 1, 0, 32'h0, 32'h0); drive(1, 1, 1, 0, 32'h0, 32'h0);
      @(negedge wb_clk_i); @(negedge wb_clk_i);
      tests++; if (grant_o !== 2'b01) begin fails++; $display("FAIL tie_first pass%0d grant got %b want 01", pass, grant_o); end
      wait_ack(0, got, rd);
      @(posedge wb_clk_i); #1 drive(0, 0, 0, 0, 32'h0, 32'h0);
      @(negedge wb_clk_i);
      if (pass == 0) begin
        tests++; if (s_cyc_o !== 1'b0) begin fails++; $display("FAIL tie_idle s_cyc_o got %b want 0", s_cyc_o); end
      end
      @(negedge wb_clk_i);
      tests++; if (grant_o !== 2'b10 || s_cyc_o !== 1'b1) begin
        fails++; $display("FAIL tie_handover pass%0d grant=%b cyc=%b want 10/1", pass, grant_o, s_cyc_o); end
      wait_ack(1, got, rd);
      @(posedge wb_clk_i); #1 drive(1, 0, 0, 0, 32'h0, 32'h0);
      @(negedge wb_clk_i); @(negedge wb_clk_i);
    end
  endtask

  task automatic test_lock_rmw();
    logic got; logic [31:0] rd;
    @(posedge wb_clk_i); #1 drive(0, 1, 1, 0, 32'h3fc, 32'h0);
    @(posedge wb_clk_i); #1 drive(1, 1, 1, 0, 32'h3fc, 32'h0);
    wait_ack(0, got, rd);
    tests++; if (got !== 1'b1 || rd !== 32'h11) begin fails++; $display("FAIL lock_lw got ack=%b dat=%h want 1/11", got, rd); end
    @(posedge wb_clk_i); #1 drive(0, 1, 0, 0, 32'h3fc, 32'h0);
    @(negedge wb_clk_i);
    tests++; if (grant_o !== 2'b01) begin fails++; $display("FAIL lock_stb_low grant got %b want 01", grant_o); end
    @(posedge wb_clk_i); #1 drive(0, 1, 1, 1, 32'h3fc, 32'h5);
    @(negedge wb_clk_i);
    tests++; if (s_adr_o !== 32'h3fc || s_dat_o !== 32'h5 || s_we_o !== 1'b1) begin
      fails++; $display("FAIL lock_sw_bus adr=%h dat=%h we=%b want 3fc/5/1", s_adr_o, s_dat_o, s_we_o); end
    wait_ack(0, got, rd);
    tests++; if (got !== 1'b1 || grant_o !== 2'b01 || m1_ack_o !== 1'b0) begin
      fails++; $display("FAIL lock_sw ack=%b grant=%b m1_ack=%b want 1/01/0", got, grant_o, m1_ack_o); end
    @(posedge wb_clk_i); #1 drive(0, 0, 0, 0, 32'h0, 32'h0);
    tests++; if (mem[255] !== 32'h5) begin fails++; $display("FAIL lock_mem got %h want 5", mem[255]); end
    wait_ack(1, got, rd);
    tests++; if (got !== 1'b1 || rd !== 32'h5) begin fails++; $display("FAIL lock_m1_rd ack=%b dat=%h want 1/5", got, rd); end
    @(posedge wb_clk_i); #1 drive(1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge wb_clk_i); @(negedge wb_clk_i);
  endtask

  task automatic test_stray();
    @(posedge wb_clk_i); #1 ack_force = 1'b1;
    @(negedge wb_clk_i);
    tests++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      fails++; $display("FAIL stray_ack m0=%b m1=%b want 0/0", m0_ack_o, m1_ack_o); end
    @(posedge wb_clk_i); #1 ack_force = 1'b0; slave_mute = 1'b1; drive(1, 1, 1, 0, 32'h10, 32'h0);
    @(negedge wb_clk_i); @(negedge wb_clk_i);
    @(posedge wb_clk_i); #1 err_force = 1'b1;
    @(negedge wb_clk_i);
    tests++; if (m1_err_o !== 1'b1 || m0_err_o !== 1'b0) begin
      fails++; $display("FAIL err_route m1=%b m0=%b want 1/0", m1_err_o, m0_err_o); end
    @(posedge wb_clk_i); #1 err_force = 1'b0;
    @(negedge wb_clk_i);
    tests++; if (m1_err_o !== 1'b0) begin fails++; $display("FAIL err_pulse m1_err got %b want 0", m1_err_o); end
    @(posedge wb_clk_i); #1 drive(1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge wb_clk_i); @(negedge wb_clk_i);
  endtask

  task automatic test_reset_mid();
    logic got; logic [31:0] rd;
    @(posedge wb_clk_i); #1 drive(1, 1, 1, 1, 32'h20, 32'hdead);
    @(negedge wb_clk_i); @(negedge wb_clk_i);
    tests++; if (s_cyc_o !== 1'b1 || grant_o !== 2'b10) begin
      fails++; $display("FAIL rstmid_pre cyc=%b grant=%b want 1/10", s_cyc_o, grant_o); end
    #1 wb_rst_i = 1'b1;
    #1;
    tests++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
      fails++; $display("FAIL rstmid_async cyc=%b stb=%b want 0/0", s_cyc_o, s_stb_o); end
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    slave_mute = 1'b0;
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    tests++; if (grant_o !== 2'b00) begin fails++; $display("FAIL rstmid_post grant got %b want 00", grant_o); end
    @(posedge wb_clk_i); #1 drive(0, 1, 1, 0, 32'h0, 32'h0); drive(1, 1, 1, 0, 32'h0, 32'h0);
    @(negedge wb_clk_i); @(negedge wb_clk_i);
    tests++; if (grant_o !== 2'b01) begin fails++; $display("FAIL rstmid_tie grant got %b want 01", grant_o); end
    wait_ack(0, got, rd);
    @(posedge wb_clk_i); #1 drive(0, 0, 0, 0, 32'h0, 32'h0); drive(1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge wb_clk_i); @(negedge wb_clk_i);
  endtask

  task automatic test_timeout();
    int   first_err = -1;
    int   pulses = 0;
    logic stb_at_err = 1'b1;
    logic held = 1'b1;
    slave_mute = 1'b1;
    @(posedge wb_clk_i); #1 drive(0, 1, 1, 0, 32'h0, 32'h0);
    @(negedge wb_clk_i);
    for (int k = 0; k <= 20; k++) begin
      @(negedge wb_clk_i);
      if (grant_o !== 2'b01 || s_cyc_o !== 1'b1) held = 1'b0;
      if (m0_err_o === 1'b1) begin
        pulses++;
        if (first_err < 0) begin first_err = k; stb_at_err = s_stb_o; end
      end
    end
    tests++; if (held !== 1'b1) begin fails++; $display("FAIL tmo_hold grant/cyc held=%b want 1", held); end
`ifdef WB_ARB_TIMEOUT_EN
    tests++; if (first_err != 16 || pulses != 1) begin
      fails++; $display("FAIL tmo_pulse at=%0d count=%0d want 16/1", first_err, pulses); end
    tests++; if (stb_at_err !== 1'b0) begin fails++; $display("FAIL tmo_stb got %b want 0", stb_at_err); end
`else
    tests++; if (pulses != 0) begin fails++; $display("FAIL tmo_none err pulses got %0d want 0", pulses); end
`endif
    @(posedge wb_clk_i); #1 drive(0, 0, 0, 0, 32'h0, 32'h0); slave_mute = 1'b0;
    @(negedge wb_clk_i); @(negedge wb_clk_i);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie_alternate();
    test_lock_rmw();
    test_stray();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
